// File: rtl/mul_arb_pkg.sv
// Shared definitions for the multiply-cell arbiter: data width, the
// in-flight tag carried alongside each multiply, and a constant-width helper.
package mul_arb_pkg;

    localparam int DATA_W   = 32;
    // Widest requester index the block supports (up to 8 requesters).
    localparam int MAX_ID_W = 3;

    // One stage of the tag pipeline: an operation is in the cell, owned by id.
    typedef struct packed {
        logic                v;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

    // Ceiling log2, never below 1 so index vectors always have a bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mul_cell_arbiter_if.sv
// Bundle of requester handshakes, multiply-cell operand/result wires and the
// shared response channel. The arbiter is the slave side.
interface mul_cell_arbiter_if
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();

    localparam int ID_W = clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W*NUM_REQ-1:0] req_src1;
    logic [DATA_W*NUM_REQ-1:0] req_src2;
    logic [DATA_W-1:0]         mul_src1;
    logic [DATA_W-1:0]         mul_src2;
    logic [DATA_W-1:0]         mul_result;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_result;

    modport slave (
        input  req_valid, req_src1, req_src2, mul_result, rsp_ready,
        output req_ready, mul_src1, mul_src2, rsp_valid, rsp_id, rsp_result
    );

    modport master (
        output req_valid, req_src1, req_src2, mul_result, rsp_ready,
        input  req_ready, mul_src1, mul_src2, rsp_valid, rsp_id, rsp_result
    );

endinterface

// File: rtl/mul_arb_rsp_fifo.sv
// Small synchronous FIFO with occupancy count. Head data reads as zero while
// empty so the response channel idles at zero.
module mul_arb_rsp_fifo
    import mul_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 34
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [clog2(DEPTH+1)-1:0]  count_o
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next pointers and count; a push into a full FIFO is allowed only when
    // the head leaves in the same cycle.
    always_comb begin
        do_push  = push_i && (!full_o || pop_i);
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/mul_cell_arbiter.sv
// Round-robin sharing of one pipelined multiply cell. Issue is credit gated so
// every result the cell produces has a guaranteed slot in the response FIFO.
module mul_cell_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 1
) (
    input logic               clk,
    input logic               reset,
    mul_cell_arbiter_if.slave bus
);

    localparam int FIFO_DEPTH = LATENCY + 1;
    localparam int ID_W       = clog2(NUM_REQ);
    localparam int CNT_W      = clog2(FIFO_DEPTH + 1);
    localparam int OCC_W      = CNT_W + 1;

    logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]          grant_idx, cand;
    logic                     grant_found;
    logic                     issue;
    tag_t [LATENCY-1:0]       tag_q, tag_d;
    logic [CNT_W-1:0]         inflight;
    logic [CNT_W-1:0]         fifo_count;
    logic [OCC_W-1:0]         occupancy;
    logic                     fifo_full, fifo_empty;
    logic [ID_W+DATA_W-1:0]   fifo_head;

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            cand = ID_W'((int'(rr_ptr_q) + j) % NUM_REQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Credit check, grant, operand mux and pointer advance. Occupancy uses the
    // registered FIFO count, so a pop frees credit one cycle later and
    // rsp_ready never reaches req_ready. Reset blocks issue immediately.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + CNT_W'(tag_q[i].v);
        end
        occupancy     = OCC_W'(fifo_count) + OCC_W'(inflight);
        issue         = grant_found && (occupancy < OCC_W'(FIFO_DEPTH)) && !reset;
        bus.req_ready = '0;
        bus.mul_src1  = '0;
        bus.mul_src2  = '0;
        rr_ptr_d      = rr_ptr_q;
        if (issue) begin
            bus.req_ready[grant_idx] = 1'b1;
            bus.mul_src1 = bus.req_src1[int'(grant_idx)*DATA_W +: DATA_W];
            bus.mul_src2 = bus.req_src2[int'(grant_idx)*DATA_W +: DATA_W];
            rr_ptr_d     = ID_W'((int'(grant_idx) + 1) % NUM_REQ);
        end
    end

    // Tag pipeline shifts in lockstep with the cell's internal stages.
    always_comb begin
        tag_d       = '0;
        tag_d[0].v  = issue;
        tag_d[0].id = MAX_ID_W'(grant_idx);
        for (int i = 1; i < LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Arbiter pointer and tag registers; reset discards all in-flight work.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
            tag_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            tag_q    <= tag_d;
        end
    end

    mul_arb_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ID_W + DATA_W)
    ) u_rsp_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (tag_q[LATENCY-1].v),
        .push_data_i ({tag_q[LATENCY-1].id[ID_W-1:0], bus.mul_result}),
        .pop_i       (bus.rsp_valid && bus.rsp_ready),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign bus.rsp_valid                 = !fifo_empty;
    assign {bus.rsp_id, bus.rsp_result}  = fifo_head;

    // Credit accounting must make a result arriving at a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(tag_q[LATENCY-1].v && fifo_full));

    // Tags only ever carry a legal requester index.
    a_id_range: assert property (@(posedge clk) disable iff (reset)
        !tag_q[LATENCY-1].v || (int'(tag_q[LATENCY-1].id) < NUM_REQ));

endmodule

// File: tb/tb_mul_cell_arbiter.sv
// Bench: two arbiters (latency 1 and 3) share one randomized stimulus and are
// each compared every cycle against a transaction-level model built from an
// outstanding-operation counter and an ordered queue of expected responses.
module tb_mul_cell_arbiter;
    import mul_arb_pkg::*;

    localparam int NR   = 4;
    localparam int ID_W = clog2(NR);
    localparam int NI   = 2;

    typedef struct {
        int          id;
        logic [31:0] res;
        int          vis;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [32*NR-1:0] req_src1 = '0;
    logic [32*NR-1:0] req_src2 = '0;
    logic            rsp_ready = 1'b0;

    always #5 clk = ~clk;

    logic [NR-1:0]   obs_ready [NI];
    logic [31:0]     obs_s1    [NI];
    logic [31:0]     obs_s2    [NI];
    logic            obs_valid [NI];
    logic [ID_W-1:0] obs_id    [NI];
    logic [31:0]     obs_res   [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int L = (gi == 0) ? 1 : 3;
        mul_cell_arbiter_if #(.NUM_REQ(NR)) bus ();
        logic [31:0] cell_q [L];

        assign bus.req_valid  = req_valid;
        assign bus.req_src1   = req_src1;
        assign bus.req_src2   = req_src2;
        assign bus.rsp_ready  = rsp_ready;
        assign bus.mul_result = cell_q[L-1];

        // Behavioural multiply cell: product of the operands, L stages deep.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s < L; s++) cell_q[s] <= '0;
            end else begin
                cell_q[0] <= bus.mul_src1 * bus.mul_src2;
                for (int s = 1; s < L; s++) cell_q[s] <= cell_q[s-1];
            end
        end

        mul_cell_arbiter #(.NUM_REQ(NR), .LATENCY(L)) u_dut (
            .clk   (clk),
            .reset (rst),
            .bus   (bus)
        );

        assign obs_ready[gi] = bus.req_ready;
        assign obs_s1[gi]    = bus.mul_src1;
        assign obs_s2[gi]    = bus.mul_src2;
        assign obs_valid[gi] = bus.rsp_valid;
        assign obs_id[gi]    = bus.rsp_id;
        assign obs_res[gi]   = bus.rsp_result;
    end

    int   lat [NI] = '{1, 3};
    int   rr_m [NI];
    int   outst_m [NI];
    int   issued_m [NI];
    int   dut_pops [NI];
    exp_t exp_q [NI][$];
    int   cyc = 0;
    bit   model_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
        end
    endtask

    // One cycle of the reference model for arbiter k, checked at negedge.
    task automatic model_step(input int k);
        bit          found, head_vis, pop;
        int          g;
        logic [NR-1:0] e_ready;
        logic [31:0] a, b, e_s1, e_s2;
        exp_t        e;
        string       p;
        p = $sformatf("L%0d", lat[k]);
        found = 1'b0;
        g = 0;
        for (int j = 0; j < NR; j++) begin
            if (!found && req_valid[(rr_m[k] + j) % NR]) begin
                found = 1'b1;
                g = (rr_m[k] + j) % NR;
            end
        end
        // At most latency+1 operations may be accepted and not yet popped.
        if (outst_m[k] >= lat[k] + 1) found = 1'b0;
        e_ready = '0;
        a = req_src1[g*32 +: 32];
        b = req_src2[g*32 +: 32];
        e_s1 = '0;
        e_s2 = '0;
        if (found) begin
            e_ready[g] = 1'b1;
            e_s1 = a;
            e_s2 = b;
        end
        head_vis = (exp_q[k].size() > 0) && (exp_q[k][0].vis <= cyc);
        check({p, " req_ready"}, 64'(obs_ready[k]), 64'(e_ready));
        check({p, " mul_src1"}, 64'(obs_s1[k]), 64'(e_s1));
        check({p, " mul_src2"}, 64'(obs_s2[k]), 64'(e_s2));
        check({p, " rsp_valid"}, 64'(obs_valid[k]), 64'(head_vis));
        check({p, " rsp_id"}, 64'(obs_id[k]), head_vis ? 64'(exp_q[k][0].id) : 64'd0);
        check({p, " rsp_result"}, 64'(obs_res[k]), head_vis ? 64'(exp_q[k][0].res) : 64'd0);
        if (obs_valid[k] && rsp_ready) dut_pops[k]++;
        pop = head_vis && rsp_ready;
        if (pop) void'(exp_q[k].pop_front());
        if (found) begin
            e.id  = g;
            e.res = a * b;
            e.vis = cyc + lat[k] + 1;
            exp_q[k].push_back(e);
            rr_m[k] = (g + 1) % NR;
            outst_m[k]++;
            issued_m[k]++;
        end
        if (pop) outst_m[k]--;
        $display("cyc=%0d %s grant=%0d rsp=%0b id=%0d res=%08h", cyc, p,
                 found ? g : -1, obs_valid[k], obs_id[k], obs_res[k]);
    endtask

    always @(negedge clk) begin
        if (model_en && !rst) begin
            for (int k = 0; k < NI; k++) model_step(k);
            cyc++;
        end
    end

    function automatic logic [31:0] pick_op();
        case ($urandom % 8)
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0001_0000;
            2:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic [NR-1:0] v, input logic rdy, input bit rand_ops);
        @(posedge clk);
        #1;
        req_valid = v;
        rsp_ready = rdy;
        if (rand_ops) begin
            for (int i = 0; i < NR; i++) begin
                req_src1[i*32 +: 32] = pick_op();
                req_src2[i*32 +: 32] = pick_op();
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < NI; k++) begin
            check({tag, " req_ready"}, 64'(obs_ready[k]), 64'd0);
            check({tag, " mul_src1"}, 64'(obs_s1[k]), 64'd0);
            check({tag, " mul_src2"}, 64'(obs_s2[k]), 64'd0);
            check({tag, " rsp_valid"}, 64'(obs_valid[k]), 64'd0);
            check({tag, " rsp_id"}, 64'(obs_id[k]), 64'd0);
            check({tag, " rsp_result"}, 64'(obs_res[k]), 64'd0);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < NI; k++) begin
            exp_q[k].delete();
            rr_m[k] = 0;
            outst_m[k] = 0;
            issued_m[k] = 0;
            dut_pops[k] = 0;
        end
    endtask

    initial begin
        clear_model();
        // Reset with requests pending: nothing may be granted.
        req_valid = '1;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_en = 1'b1;

        // Single operation: requester 2 sends 7 x 6.
        req_src1[2*32 +: 32] = 32'd7;
        req_src2[2*32 +: 32] = 32'd6;
        drive(4'b0100, 1'b1, 1'b0);
        repeat (6) drive(4'b0000, 1'b1, 1'b0);

        // Wrap and truncation corners on requesters 0 and 1.
        req_src1[0 +: 32]  = 32'hFFFF_FFFF;
        req_src2[0 +: 32]  = 32'hFFFF_FFFF;
        req_src1[32 +: 32] = 32'h0001_0000;
        req_src2[32 +: 32] = 32'h0001_0000;
        drive(4'b0011, 1'b1, 1'b0);
        drive(4'b0010, 1'b1, 1'b0);
        repeat (6) drive(4'b0000, 1'b1, 1'b0);

        // Fairness: everyone requesting, consumer always ready.
        repeat (24) drive(4'b1111, 1'b1, 1'b1);
        repeat (6) drive(4'b0000, 1'b1, 1'b0);

        // Backpressure then release.
        repeat (12) drive(4'b1111, 1'b0, 1'b1);
        repeat (12) drive(4'b1111, 1'b1, 1'b1);
        repeat (6) drive(4'b0000, 1'b1, 1'b0);

        // Random traffic with random consumer stalls.
        repeat (400) drive(4'($urandom), ($urandom % 4) != 0, 1'b1);
        repeat (8) drive(4'b0000, 1'b1, 1'b0);

        // Reset while operations are in flight.
        repeat (2) drive(4'b1111, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        repeat (10) drive(4'b1111, 1'b1, 1'b1);

        // Drain: every accepted operation since the last reset must come back.
        repeat (12) drive(4'b0000, 1'b1, 1'b0);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("L%0d drained", lat[k]), 64'(dut_pops[k]), 64'(issued_m[k]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
